registro_solicitudes: RTL and testbench

// - Upstream stage of the elevator top level: turns raw button inputs into latched floor requests.
// - Debounces and latches the 10 request buttons; the latched vector drives the button lights (luces).
// - Clears requests when the controller reports a floor was served.
// - Publishes registered per-direction summaries that the controller FSM uses to pick motion.
// - Bit map (fixed): 0 F1 up, 1 F2 down, 2 F2 up, 3 F3 down, 4 F3 up, 5 F4 down, 6..9 cabin F1..F4.
// - Floor code piso[1:0]: 0..3 = floors 1..4. Direction: 1 = up, 0 = down.

---
 rtl/registro_solicitudes_pkg.sv | 49 ++++
 rtl/registro_solicitudes_antirrebote.sv | 61 ++++++
 rtl/registro_solicitudes.sv | 117 +++++++++++
 tb/tb_registro_solicitudes.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/registro_solicitudes_pkg.sv
// +----------------------------------------------------------------------+
// | pkg_ascensor: elevator request bit map and floor/direction helpers   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package pkg_ascensor;

    localparam int NUM_PISOS  = 4;

    localparam int BTN_P1_SUB = 0;
    localparam int BTN_P2_BAJ = 1;
    localparam int BTN_P2_SUB = 2;
    localparam int BTN_P3_BAJ = 3;
    localparam int BTN_P3_SUB = 4;
    localparam int BTN_P4_BAJ = 5;
    localparam int BTN_CAB_P1 = 6;
    localparam int BTN_CAB_P2 = 7;
    localparam int BTN_CAB_P3 = 8;
    localparam int BTN_CAB_P4 = 9;

    function automatic logic [1:0] piso_de_bit(input int idx);
        logic [1:0] piso;
        case (idx)
            BTN_P1_SUB, BTN_CAB_P1:             piso = 2'd0;
            BTN_P2_BAJ, BTN_P2_SUB, BTN_CAB_P2: piso = 2'd1;
            BTN_P3_BAJ, BTN_P3_SUB, BTN_CAB_P3: piso = 2'd2;
            BTN_P4_BAJ, BTN_CAB_P4:             piso = 2'd3;
            default:                            piso = 2'd3;
        endcase
        return piso;
    endfunction

    // Hall button at a floor for a direction (1 = up); -1 where none exists.
    function automatic int bit_hall(input logic [1:0] piso, input logic dir);
        int p;
        int idx;
        p = int'(piso);
        if (dir) begin
            idx = (p < NUM_PISOS - 1) ? (BTN_P1_SUB + 2 * p) : -1;
        end else begin
            idx = (p > 0) ? (BTN_P2_BAJ + 2 * (p - 1)) : -1;
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/registro_solicitudes_antirrebote.sv
// +----------------------------------------------------------------------+
// | antirrebote: 2-flop sync, debounce and rising-edge pulse of 1 button |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module antirrebote #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_boton,
    output logic o_pulso
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          estable_q, estable_d;
    logic          pulso_q, pulso_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d   = i_boton;
        sync2_d   = sync1_q;
        estable_d = estable_q;
        pulso_d   = 1'b0;
        cnt_d     = '0;
        if (sync2_q != estable_q) begin
            if (cnt_q == CNT_MAX) begin
                estable_d = sync2_q;
                pulso_d   = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            estable_q <= 1'b0;
            pulso_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            estable_q <= estable_d;
            pulso_q   <= pulso_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_pulso = pulso_q;

endmodule

`default_nettype wire

// File: rtl/registro_solicitudes.sv
// +----------------------------------------------------------------------+
// | registro_solicitudes: latched floor requests and direction summaries |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module registro_solicitudes
    import pkg_ascensor::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int NUM_BOTONES     = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BOTONES-1:0] botones,
    input  logic [1:0]             piso_actual,
    input  logic                   atender,
    input  logic                   dir_atender,
    output logic [NUM_BOTONES-1:0] luces,
    output logic                   hay_arriba,
    output logic                   hay_abajo,
    output logic                   hay_aqui,
    output logic                   hay_pendiente
);

    logic [NUM_BOTONES-1:0] w_pulsos;
    logic [NUM_BOTONES-1:0] w_clr;
    logic                   w_mas_alla;

    logic [NUM_BOTONES-1:0] luces_q, luces_d;
    logic                   arriba_q, arriba_d;
    logic                   abajo_q, abajo_d;
    logic                   aqui_q, aqui_d;
    logic                   pendiente_q, pendiente_d;

    generate
        for (genvar gi = 0; gi < NUM_BOTONES; gi++) begin : g_antirrebote
            antirrebote #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_antirrebote (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_boton(botones[gi]),
                .o_pulso(w_pulsos[gi])
            );
        end
    endgenerate

    // Any request still waiting beyond this floor in the leaving direction.
    always_comb begin
        w_mas_alla = 1'b0;
        for (int i = 0; i < NUM_BOTONES; i++) begin
            if (luces_q[i]) begin
                if (dir_atender ? (piso_de_bit(i) > piso_actual)
                                : (piso_de_bit(i) < piso_actual)) begin
                    w_mas_alla = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_BOTONES; i++) begin
            if (atender) begin
                if ((i == BTN_CAB_P1 + int'(piso_actual)) ||
                    (i == bit_hall(piso_actual, dir_atender)) ||
                    ((piso_actual == 2'd0) && (i == BTN_P1_SUB)) ||
                    ((piso_actual == 2'd3) && (i == BTN_P4_BAJ)) ||
                    (!w_mas_alla && (i == bit_hall(piso_actual, !dir_atender)))) begin
                    w_clr[i] = 1'b1;
                end
            end
        end
    end

    // Clear has priority: the passenger on that button is being served now.
    always_comb begin
        luces_d     = (luces_q | w_pulsos) & ~w_clr;
        arriba_d    = 1'b0;
        abajo_d     = 1'b0;
        aqui_d      = 1'b0;
        pendiente_d = |luces_q;
        for (int i = 0; i < NUM_BOTONES; i++) begin
            if (luces_q[i]) begin
                if (piso_de_bit(i) > piso_actual)  arriba_d = 1'b1;
                if (piso_de_bit(i) < piso_actual)  abajo_d  = 1'b1;
                if (piso_de_bit(i) == piso_actual) aqui_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            luces_q     <= '0;
            arriba_q    <= 1'b0;
            abajo_q     <= 1'b0;
            aqui_q      <= 1'b0;
            pendiente_q <= 1'b0;
        end else begin
            luces_q     <= luces_d;
            arriba_q    <= arriba_d;
            abajo_q     <= abajo_d;
            aqui_q      <= aqui_d;
            pendiente_q <= pendiente_d;
        end
    end

    assign luces         = luces_q;
    assign hay_arriba    = arriba_q;
    assign hay_abajo     = abajo_q;
    assign hay_aqui      = aqui_q;
    assign hay_pendiente = pendiente_q;

endmodule

`default_nettype wire

// File: tb/tb_registro_solicitudes.sv
// +----------------------------------------------------------------------+
// | tb_registro_solicitudes: bench for the request register              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_registro_solicitudes;

    localparam int DEB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] botones = '0;
    logic [1:0] piso_actual = '0;
    logic       atender = 1'b0;
    logic       dir_atender = 1'b0;
    logic [9:0] luces;
    logic       hay_arriba, hay_abajo, hay_aqui, hay_pendiente;

    always #5 clk = ~clk;

    registro_solicitudes #(
        .DEBOUNCE_CYCLES(DEB),
        .NUM_BOTONES    (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .botones      (botones),
        .piso_actual  (piso_actual),
        .atender      (atender),
        .dir_atender  (dir_atender),
        .luces        (luces),
        .hay_arriba   (hay_arriba),
        .hay_abajo    (hay_abajo),
        .hay_aqui     (hay_aqui),
        .hay_pendiente(hay_pendiente)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: floor tables, sample windows, request set.
    int floor_of[10] = '{0, 1, 1, 2, 2, 3, 0, 1, 2, 3};
    int up_map[4]    = '{0, 2, 4, -1};
    int down_map[4]  = '{-1, 1, 3, 5};

    logic [9:0]     m_luces = '0, m_set = '0, m_stable = '0, r1 = '0, r2 = '0;
    logic           m_arr = 1'b0, m_abj = 1'b0, m_aqui = 1'b0, m_pend = 1'b0;
    logic [DEB-1:0] win[10];
    logic [9:0]     old_l, clr;
    bit             beyond;
    int             p, h, o;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_luces = '0; m_set = '0; m_stable = '0; r1 = '0; r2 = '0;
            m_arr = 1'b0; m_abj = 1'b0; m_aqui = 1'b0; m_pend = 1'b0;
            for (int i = 0; i < 10; i++) win[i] = '0;
        end else begin
            old_l = m_luces;
            p = int'(piso_actual);
            m_arr = 1'b0; m_abj = 1'b0; m_aqui = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (old_l[i] && floor_of[i] > p)  m_arr  = 1'b1;
                if (old_l[i] && floor_of[i] < p)  m_abj  = 1'b1;
                if (old_l[i] && floor_of[i] == p) m_aqui = 1'b1;
            end
            m_pend = (old_l != 0);
            clr = '0;
            if (atender) begin
                clr[6 + p] = 1'b1;
                h = dir_atender ? up_map[p] : down_map[p];
                if (h >= 0) clr[h] = 1'b1;
                if (p == 0) clr[0] = 1'b1;
                if (p == 3) clr[5] = 1'b1;
                beyond = 1'b0;
                for (int i = 0; i < 10; i++)
                    if (old_l[i] && (dir_atender ? floor_of[i] > p : floor_of[i] < p)) beyond = 1'b1;
                if (!beyond) begin
                    o = dir_atender ? down_map[p] : up_map[p];
                    if (o >= 0) clr[o] = 1'b1;
                end
            end
            m_luces = (old_l | m_set) & ~clr;
            // A level is accepted after DEB consecutive synced samples that disagree with it.
            for (int i = 0; i < 10; i++) begin
                win[i] = {win[i][DEB-2:0], r2[i]};
                m_set[i] = 1'b0;
                if (win[i] == {DEB{~m_stable[i]}}) begin
                    m_stable[i] = r2[i];
                    m_set[i]    = r2[i];
                end
            end
            r2 = r1;
            r1 = botones;
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            check("ciclo", {18'b0, luces, hay_arriba, hay_abajo, hay_aqui, hay_pendiente},
                  {18'b0, m_luces, m_arr, m_abj, m_aqui, m_pend});
    end

    task automatic ciclos(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reiniciar();
        botones = '0; atender = 1'b0; rst_n = 1'b0;
        ciclos(3);
        rst_n = 1'b1;
        ciclos(1);
    endtask

    task automatic pulso_atender(input logic d);
        atender = 1'b1; dir_atender = d;
        ciclos(1);
        atender = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; botones = 10'h3FF;
        ciclos(4);
        chk_en = 1'b1;
        check("reset_luces", {22'b0, luces}, 32'h0);
        check("reset_resumen", {28'b0, hay_arriba, hay_abajo, hay_aqui, hay_pendiente}, 32'h0);
        rst_n = 1'b1;
        ciclos(18);
        check("antes_debounce", {22'b0, luces}, 32'h0);
        ciclos(1);
        check("tras_debounce", {22'b0, luces}, 32'h3FF);
        ciclos(1);
        check("resumen_p0", {28'b0, hay_arriba, hay_abajo, hay_aqui, hay_pendiente}, 32'hB);

        // Bounce on cabin F2, then a steady hold.
        reiniciar();
        for (int k = 0; k < 40; k++) begin
            botones[7] = ((k / 3) % 2 == 0);
            ciclos(1);
        end
        check("rebote_sin_set", {31'b0, luces[7]}, 32'h0);
        botones[7] = 1'b1;
        ciclos(18);
        check("rebote_casi", {31'b0, luces[7]}, 32'h0);
        ciclos(1);
        check("rebote_set", {31'b0, luces[7]}, 32'h1);
        botones[7] = 1'b0;
        ciclos(25);
        check("soltar_sin_efecto", {31'b0, luces[7]}, 32'h1);

        // Serve going up at F2 with a cabin call for F4 pending.
        reiniciar();
        piso_actual = 2'd1; botones = 10'h204;
        ciclos(20);
        botones = '0;
        ciclos(2);
        check("subir_previo", {22'b0, luces}, 32'h204);
        pulso_atender(1'b1);
        check("subir_luces", {22'b0, luces}, 32'h200);
        ciclos(1);
        check("subir_resumen", {29'b0, hay_arriba, hay_abajo, hay_aqui}, 32'h4);

        // Reversal at F3 with nothing above.
        reiniciar();
        piso_actual = 2'd2; botones = 10'h00A;
        ciclos(20);
        botones = '0;
        ciclos(2);
        pulso_atender(1'b1);
        check("reversa_luces", {22'b0, luces}, 32'h002);
        ciclos(1);
        check("reversa_resumen", {29'b0, hay_arriba, hay_abajo, hay_aqui}, 32'h2);

        // Set and clear of cabin F3 on the same edge.
        reiniciar();
        piso_actual = 2'd2; botones = 10'h100;
        ciclos(18);
        pulso_atender(1'b1);
        check("colision", {31'b0, luces[8]}, 32'h0);
        ciclos(5);
        check("colision_tarde", {31'b0, luces[8]}, 32'h0);
        botones = '0;
        ciclos(22);
        botones = 10'h100;
        ciclos(19);
        check("colision_reset", {31'b0, luces[8]}, 32'h1);

        // Terminal floor F4.
        reiniciar();
        piso_actual = 2'd3; botones = 10'h020;
        ciclos(20);
        botones = '0;
        ciclos(2);
        check("terminal_previo", {22'b0, luces}, 32'h020);
        check("terminal_arriba0", {31'b0, hay_arriba}, 32'h0);
        pulso_atender(1'b1);
        check("terminal_luces", {31'b0, luces[5]}, 32'h0);
        ciclos(1);
        check("terminal_arriba1", {31'b0, hay_arriba}, 32'h0);

        // Random traffic with one mid-run reset.
        reiniciar();
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < 10; b++)
                if ($urandom_range(0, 29) == 0) botones[b] = ~botones[b];
            if ($urandom_range(0, 9) == 0) piso_actual = 2'($urandom_range(0, 3));
            atender     = ($urandom_range(0, 11) == 0);
            dir_atender = 1'($urandom_range(0, 1));
            rst_n       = !(n >= 2000 && n < 2003);
            ciclos(1);
        end
        atender = 1'b0; rst_n = 1'b1;
        ciclos(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
